// File: rtl/jk_ff_pkg.sv
// JK control codes shared by the jk_ff cell decode.
package jk_ff_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

endpackage

// File: rtl/jk_ff_cell.sv
// Single-bit JK flip-flop with asynchronous active-low preset and clear.
module jk_ff_cell
  import jk_ff_pkg::*;
(
  input  logic clk,
  input  logic pr,
  input  logic cl,
  input  logic j,
  input  logic k,
  output logic q
);

  logic   r;
  jk_op_e op;

  assign op = jk_op_e'({j, k});

  // Preset has priority inside the register so that releasing clear while
  // preset is still low reveals the preset value. Clear dominance at the
  // output is provided by the mux below.
  always_ff @(posedge clk or negedge pr or negedge cl) begin
    if (!pr)      r <= 1'b1;
    else if (!cl) r <= 1'b0;
    else begin
      case (op)
        JK_HOLD:   r <= r;
        JK_RESET:  r <= 1'b0;
        JK_SET:    r <= 1'b1;
        JK_TOGGLE: r <= ~r;
        default:   r <= 1'bx;
      endcase
    end
  end

  assign q = cl ? r : 1'b0;

endmodule

// File: rtl/jk_ff.sv
// WIDTH independent JK cells sharing clock, preset and clear; q_bar = ~q.
module jk_ff #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clk,
  input  logic             pr,
  input  logic             cl
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_ff_cell u_cell (
        .clk (clk),
        .pr  (pr),
        .cl  (cl),
        .j   (j[i]),
        .k   (k[i]),
        .q   (q[i])
      );
    end
  endgenerate

  assign q_bar = ~q;

endmodule

// File: tb/tb_jk_ff.sv
// Directed-vector bench for jk_ff: one WIDTH=1 and one WIDTH=4 instance.
`timescale 1ns/100ps
module tb_jk_ff;

  logic       clk = 1'b0;
  logic       pr, cl;
  logic       j, k;
  logic [3:0] j4, k4;
  logic       q, q_bar;
  logic [3:0] q4, q_bar4;

  int nchk = 0;
  int nerr = 0;

  jk_ff #(.WIDTH(1)) dut1 (
    .q(q), .q_bar(q_bar), .j(j), .k(k), .clk(clk), .pr(pr), .cl(cl)
  );

  jk_ff #(.WIDTH(4)) dut4 (
    .q(q4), .q_bar(q_bar4), .j(j4), .k(k4), .clk(clk), .pr(pr), .cl(cl)
  );

  always #1 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Check q and its complement of the single-bit instance.
  task automatic chk1(input string tag, input logic exp);
    chk({tag, ".q"}, {3'b0, q}, {3'b0, exp});
    chk({tag, ".qb"}, {3'b0, q_bar}, {3'b0, ~exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #0.5;
  endtask

  initial begin
    cl = 1'b0; pr = 1'b1;
    j = 1'b0; k = 1'b0;
    j4 = 4'b0; k4 = 4'b0;

    // 1: reset then divide-by-2
    #0.3;
    chk1("rst", 1'b0);
    chk("rst.q4", q4, 4'b0000);
    tick();
    cl = 1'b1; j = 1'b1; k = 1'b1;
    tick(); chk1("tgl1", 1'b1);
    tick(); chk1("tgl2", 1'b0);
    tick(); chk1("tgl3", 1'b1);
    tick(); chk1("tgl4", 1'b0);

    // 2: set, hold x5, reset
    j = 1'b1; k = 1'b0;
    tick(); chk1("set", 1'b1);
    j = 1'b0; k = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk1("hold", 1'b1);
    end
    j = 1'b0; k = 1'b1;
    tick(); chk1("reset", 1'b0);

    // 3: async clear mid-toggle
    j = 1'b1; k = 1'b1;
    tick(); chk1("mt1", 1'b1);
    tick(); chk1("mt2", 1'b0);
    tick(); chk1("mt3", 1'b1);
    #0.2 cl = 1'b0;
    #0.1 chk1("aclr", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk1("clrhold", 1'b0);
    end
    cl = 1'b1;
    #0.1 chk1("clrrel", 1'b0);
    tick(); chk1("resume1", 1'b1);
    tick(); chk1("resume2", 1'b0);

    // 4: preset / clear priority
    j = 1'b0; k = 1'b0;
    pr = 1'b0;
    #0.1 chk1("pre", 1'b1);
    cl = 1'b0;
    #0.1 chk1("prcl", 1'b0);
    cl = 1'b1;
    #0.1 chk1("clrel", 1'b1);
    pr = 1'b1;
    #0.1 chk1("prrel", 1'b1);
    tick(); chk1("prhold", 1'b1);

    // 5: edge coincident with active preset, k=1 ignored
    j = 1'b0; k = 1'b1;
    pr = 1'b0;
    tick(); chk1("preedge", 1'b1);
    pr = 1'b1;
    tick(); chk1("postpre", 1'b0);

    // 6: WIDTH=4 mixed per-bit ops from 0000
    cl = 1'b0;
    #0.1 chk("w4clr", q4, 4'b0000);
    cl = 1'b1;
    j4 = 4'b0101; k4 = 4'b0011;
    tick();
    chk("w4e1.q", q4, 4'b0101);
    chk("w4e1.qb", q_bar4, 4'b1010);
    tick();
    chk("w4e2.q", q4, 4'b0100);
    chk("w4e2.qb", q_bar4, 4'b1011);
    j4 = 4'b1000; k4 = 4'b0100;
    tick();
    chk("w4e3.q", q4, 4'b1000);
    chk("w4e3.qb", q_bar4, 4'b0111);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
